// File: rtl/instr_dec_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for the RV32I decode stage.
// The slave modport is the decode stage itself; master is whoever drives fetch and sinks decode.
interface instr_dec_stage_if #(
    parameter int WIDTH       = 32,
    parameter int INSTR_TYPES = 6,
    parameter int ALU_OP      = 4,
    parameter int BR_OP       = 3,
    parameter int REG_IDX     = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_instr;
    logic [WIDTH-1:0]       in_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_pc;
    logic [INSTR_TYPES-1:0] instr_type;
    logic                   alu_en;
    logic [ALU_OP-1:0]      alu_op;
    logic                   branch_en;
    logic [BR_OP-1:0]       branch_op;
    logic                   jump;
    logic                   mem_rd;
    logic                   mem_wr;
    logic [2:0]             mem_size;
    logic [REG_IDX-1:0]     rd;
    logic [REG_IDX-1:0]     rs1;
    logic [REG_IDX-1:0]     rs2;
    logic                   rd_we;
    logic [WIDTH-1:0]       imm;
    logic                   illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, instr_type, alu_en, alu_op, branch_en, branch_op,
               jump, mem_rd, mem_wr, mem_size, rd, rs1, rs2, rd_we, imm, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, instr_type, alu_en, alu_op, branch_en, branch_op,
               jump, mem_rd, mem_wr, mem_size, rd, rs1, rs2, rd_we, imm, illegal
    );
endinterface

// File: rtl/instr_dec_stage.sv
// Registered RV32I decode stage: combinational decode of the fetched word into an
// output register backed by one skid entry, with flush and illegal-encoding detection.
module instr_dec_stage #(
    parameter int WIDTH       = 32,
    parameter int INSTR_TYPES = 6,
    parameter int ALU_OP      = 4,
    parameter int BR_OP       = 3,
    parameter int REG_IDX     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    instr_dec_stage_if.slave  bus
);
    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;
    localparam logic [6:0] OPC_FENCE = 7'b0001111, OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [INSTR_TYPES-1:0] TYPE_J = 6'b100000, TYPE_U = 6'b010000, TYPE_B = 6'b001000;
    localparam logic [INSTR_TYPES-1:0] TYPE_S = 6'b000100, TYPE_I = 6'b000010, TYPE_R = 6'b000001;

    localparam logic [ALU_OP-1:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [ALU_OP-1:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [ALU_OP-1:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [WIDTH-1:0]       pc;
        logic [INSTR_TYPES-1:0] itype;
        logic                   aluEn;
        logic [ALU_OP-1:0]      aluOp;
        logic                   branchEn;
        logic [BR_OP-1:0]       branchOp;
        logic                   jump;
        logic                   memRd;
        logic                   memWr;
        logic [2:0]             memSize;
        logic [REG_IDX-1:0]     rd;
        logic [REG_IDX-1:0]     rs1;
        logic [REG_IDX-1:0]     rs2;
        logic                   rdWe;
        logic [WIDTH-1:0]       imm;
        logic                   illegal;
    } bundle_t;

    logic [WIDTH-1:0] instr;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] immI, immS, immB, immU, immJ;
    logic [ALU_OP-1:0] funct3Alu;
    logic             legal, writesRd, usesAlu;
    bundle_t          decBundle;

    bundle_t outBundle_q, outBundle_d, skidBundle_q, skidBundle_d;
    logic    outValid_q, outValid_d, skidValid_q, skidValid_d;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign immI = {{20{instr[31]}}, instr[31:20]};
    assign immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign immU = {instr[31:12], 12'b0};
    assign immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Shared funct3 ALU mapping for OP and OP-IMM; bit 30 picks the arithmetic right shift.
    always_comb begin
        funct3Alu = ALU_ADD;
        case (funct3)
            3'b000:  funct3Alu = ALU_ADD;
            3'b001:  funct3Alu = ALU_SLL;
            3'b010:  funct3Alu = ALU_SLT;
            3'b011:  funct3Alu = ALU_SLTU;
            3'b100:  funct3Alu = ALU_XOR;
            3'b101:  funct3Alu = instr[30] ? ALU_SRA : ALU_SRL;
            3'b110:  funct3Alu = ALU_OR;
            default: funct3Alu = ALU_AND;
        endcase
    end

    always_comb begin
        decBundle     = '0;
        legal         = 1'b1;
        writesRd      = 1'b0;
        usesAlu       = 1'b1;
        decBundle.pc  = bus.in_pc;
        decBundle.rd  = instr[11:7];
        decBundle.rs1 = instr[19:15];
        decBundle.rs2 = instr[24:20];
        case (opcode)
            OPC_LUI: begin
                decBundle.itype = TYPE_U; decBundle.aluOp = ALU_PASSB; decBundle.imm = immU; writesRd = 1'b1;
            end
            OPC_AUIPC: begin
                decBundle.itype = TYPE_U; decBundle.imm = immU; writesRd = 1'b1;
            end
            OPC_JAL: begin
                decBundle.itype = TYPE_J; decBundle.jump = 1'b1; decBundle.imm = immJ; writesRd = 1'b1;
            end
            OPC_JALR: begin
                decBundle.itype = TYPE_I; decBundle.jump = 1'b1; decBundle.imm = immI; writesRd = 1'b1;
                legal = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                decBundle.itype = TYPE_B; decBundle.branchEn = 1'b1; decBundle.branchOp = funct3;
                decBundle.aluOp = ALU_SUB; decBundle.imm = immB;
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_LOAD: begin
                decBundle.itype = TYPE_I; decBundle.memRd = 1'b1; decBundle.memSize = funct3;
                decBundle.imm = immI; writesRd = 1'b1;
                legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            end
            OPC_STORE: begin
                decBundle.itype = TYPE_S; decBundle.memWr = 1'b1; decBundle.memSize = funct3;
                decBundle.imm = immS;
                legal = (funct3 <= 3'b010);
            end
            OPC_OPIMM: begin
                decBundle.itype = TYPE_I; decBundle.aluOp = funct3Alu; decBundle.imm = immI; writesRd = 1'b1;
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'b0);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'b0) || (funct7 == F7_ALT);
            end
            OPC_OP: begin
                decBundle.itype = TYPE_R; writesRd = 1'b1;
                decBundle.aluOp = (funct3 == 3'b000 && instr[30]) ? ALU_SUB : funct3Alu;
                if (funct7 == F7_ALT)
                    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                else
                    legal = (funct7 == 7'b0);
            end
            OPC_FENCE, OPC_SYSTEM: begin
                decBundle.itype = TYPE_I; decBundle.imm = immI; usesAlu = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        decBundle.aluEn   = legal & usesAlu;
        decBundle.rdWe    = legal & writesRd & (decBundle.rd != '0);
        decBundle.illegal = ~legal;
        if (!legal) begin
            decBundle.itype    = '0;
            decBundle.branchEn = 1'b0;
            decBundle.jump     = 1'b0;
            decBundle.memRd    = 1'b0;
            decBundle.memWr    = 1'b0;
        end
    end

    // The skid entry only fills while the output is stalled, and always drains ahead of new input.
    always_comb begin
        outValid_d   = outValid_q;
        outBundle_d  = outBundle_q;
        skidValid_d  = skidValid_q;
        skidBundle_d = skidBundle_q;
        if (flush) begin
            outValid_d   = 1'b0;
            outBundle_d  = '0;
            skidValid_d  = 1'b0;
            skidBundle_d = '0;
        end else if (!outValid_q || bus.out_ready) begin
            if (skidValid_q) begin
                outBundle_d = skidBundle_q;
                outValid_d  = 1'b1;
                skidValid_d = 1'b0;
            end else if (bus.in_valid) begin
                outBundle_d = decBundle;
                outValid_d  = 1'b1;
            end else begin
                outValid_d  = 1'b0;
            end
        end else if (bus.in_valid && !skidValid_q) begin
            skidBundle_d = decBundle;
            skidValid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q   <= 1'b0;
            outBundle_q  <= '0;
            skidValid_q  <= 1'b0;
            skidBundle_q <= '0;
        end else begin
            outValid_q   <= outValid_d;
            outBundle_q  <= outBundle_d;
            skidValid_q  <= skidValid_d;
            skidBundle_q <= skidBundle_d;
        end
    end

    assign bus.in_ready   = ~skidValid_q;
    assign bus.out_valid  = outValid_q;
    assign bus.out_pc     = outBundle_q.pc;
    assign bus.instr_type = outBundle_q.itype;
    assign bus.alu_en     = outBundle_q.aluEn;
    assign bus.alu_op     = outBundle_q.aluOp;
    assign bus.branch_en  = outBundle_q.branchEn;
    assign bus.branch_op  = outBundle_q.branchOp;
    assign bus.jump       = outBundle_q.jump;
    assign bus.mem_rd     = outBundle_q.memRd;
    assign bus.mem_wr     = outBundle_q.memWr;
    assign bus.mem_size   = outBundle_q.memSize;
    assign bus.rd         = outBundle_q.rd;
    assign bus.rs1        = outBundle_q.rs1;
    assign bus.rs2        = outBundle_q.rs2;
    assign bus.rd_we      = outBundle_q.rdWe;
    assign bus.imm        = outBundle_q.imm;
    assign bus.illegal    = outBundle_q.illegal;
endmodule

// File: tb/tb_instr_dec_stage.sv
// Directed and randomized bench for instr_dec_stage, scored against an in-order
// two-deep bundle queue fed by an instruction-level reference decoder.
module tb_instr_dec_stage;
    typedef struct {
        logic [31:0] pc;
        logic [5:0]  itype;
        logic        aluEn;
        logic [3:0]  aluOp;
        logic        brEn;
        logic [2:0]  brOp;
        logic        jump;
        logic        memRd;
        logic        memWr;
        logic [2:0]  memSize;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rdWe;
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    instr_dec_stage_if bus ();

    instr_dec_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] sext(logic [31:0] w, logic [31:0] signMask);
        return w[31] ? signMask : 32'h0;
    endfunction

    // Reference decoder: immediates rebuilt by shifting and masking the raw word.
    function automatic exp_t refDecode(logic [31:0] w, logic [31:0] pc);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic legal, writes, alu;
        logic [3:0] aluTab [8];
        aluTab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        e = '{pc: pc, itype: 6'd0, aluEn: 1'b0, aluOp: 4'd0, brEn: 1'b0, brOp: 3'd0, jump: 1'b0,
              memRd: 1'b0, memWr: 1'b0, memSize: 3'd0, rd: w[11:7], rs1: w[19:15], rs2: w[24:20],
              rdWe: 1'b0, imm: 32'h0, illegal: 1'b0};
        legal = 1'b1; writes = 1'b0; alu = 1'b1;
        case (op)
            7'h37: begin e.itype = 6'b010000; e.aluOp = 4'd10; e.imm = w & 32'hFFFF_F000; writes = 1'b1; end
            7'h17: begin e.itype = 6'b010000; e.imm = w & 32'hFFFF_F000; writes = 1'b1; end
            7'h6F: begin
                e.itype = 6'b100000; e.jump = 1'b1; writes = 1'b1;
                e.imm = sext(w, 32'hFFF0_0000) | (w & 32'h000F_F000) | ((w >> 9) & 32'h800) | ((w >> 20) & 32'h7FE);
            end
            7'h67: begin
                e.itype = 6'b000010; e.jump = 1'b1; writes = 1'b1; legal = (f3 == 3'd0);
                e.imm = sext(w, 32'hFFFF_F800) | ((w >> 20) & 32'h7FF);
            end
            7'h63: begin
                e.itype = 6'b001000; e.brEn = 1'b1; e.brOp = f3; e.aluOp = 4'd1;
                legal = !(f3 == 3'd2 || f3 == 3'd3);
                e.imm = sext(w, 32'hFFFF_F000) | ((w << 4) & 32'h800) | ((w >> 20) & 32'h7E0) | ((w >> 7) & 32'h1E);
            end
            7'h03: begin
                e.itype = 6'b000010; e.memRd = 1'b1; e.memSize = f3; writes = 1'b1;
                legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
                e.imm = sext(w, 32'hFFFF_F800) | ((w >> 20) & 32'h7FF);
            end
            7'h23: begin
                e.itype = 6'b000100; e.memWr = 1'b1; e.memSize = f3; legal = (f3 < 3'd3);
                e.imm = sext(w, 32'hFFFF_F800) | ((w >> 20) & 32'h7E0) | ((w >> 7) & 32'h1F);
            end
            7'h13: begin
                e.itype = 6'b000010; writes = 1'b1;
                e.aluOp = (f3 == 3'd5 && w[30]) ? 4'd7 : aluTab[f3];
                if (f3 == 3'd1) legal = (f7 == 7'h00);
                if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
                e.imm = sext(w, 32'hFFFF_F800) | ((w >> 20) & 32'h7FF);
            end
            7'h33: begin
                e.itype = 6'b000001; writes = 1'b1;
                e.aluOp = (f3 == 3'd0 && w[30]) ? 4'd1 : ((f3 == 3'd5 && w[30]) ? 4'd7 : aluTab[f3]);
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'h0F, 7'h73: begin
                e.itype = 6'b000010; alu = 1'b0;
                e.imm = sext(w, 32'hFFFF_F800) | ((w >> 20) & 32'h7FF);
            end
            default: legal = 1'b0;
        endcase
        e.aluEn = legal && alu;
        e.rdWe = legal && writes && (e.rd != 5'd0);
        e.illegal = !legal;
        if (!legal) begin
            e.itype = 6'd0; e.brEn = 1'b0; e.jump = 1'b0; e.memRd = 1'b0; e.memWr = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, advances the queue model across the edge, then waits to sample.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic ordy, input logic fl, input logic rs);
        logic accept, popped;
        bus.in_valid = v; bus.in_instr = instr; bus.in_pc = pc; bus.out_ready = ordy;
        flush = fl; rst = rs;
        if (rs || fl) begin
            sb.delete();
        end else begin
            accept = v && (sb.size() < 2);
            popped = (sb.size() > 0) && ordy;
            if (popped) void'(sb.pop_front());
            if (accept) sb.push_back(refDecode(instr, pc));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(sb.size() < 2));
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(sb.size() > 0));
        if (sb.size() > 0) begin
            e = sb[0];
            check({tag, ".out_pc"}, 64'(bus.out_pc), 64'(e.pc));
            check({tag, ".type"}, 64'(bus.instr_type), 64'(e.itype));
            check({tag, ".illegal"}, 64'(bus.illegal), 64'(e.illegal));
            check({tag, ".enables"}, 64'({bus.alu_en, bus.branch_en, bus.jump, bus.mem_rd, bus.mem_wr, bus.rd_we}),
                  64'({e.aluEn, e.brEn, e.jump, e.memRd, e.memWr, e.rdWe}));
            check({tag, ".regs"}, 64'({bus.rd, bus.rs1, bus.rs2}), 64'({e.rd, e.rs1, e.rs2}));
            if (!e.illegal) begin
                check({tag, ".imm"}, 64'(bus.imm), 64'(e.imm));
                check({tag, ".br_mem"}, 64'({bus.branch_op, bus.mem_size}), 64'({e.brOp, e.memSize}));
                if (e.aluEn) check({tag, ".alu_op"}, 64'(bus.alu_op), 64'(e.aluOp));
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        check({tag, ".rst_ctrl"}, 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
        check({tag, ".rst_pc_imm"}, {bus.out_pc, bus.imm}, 64'h0);
        check({tag, ".rst_fields"}, 64'({bus.instr_type, bus.alu_en, bus.alu_op, bus.branch_en, bus.branch_op,
              bus.jump, bus.mem_rd, bus.mem_wr, bus.mem_size, bus.rd, bus.rs1, bus.rs2, bus.rd_we, bus.illegal}), 64'h0);
    endtask

    function automatic logic [31:0] randInstr();
        logic [6:0] opcs [11];
        logic [31:0] w;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        w = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            w[6:0] = opcs[$urandom_range(0, 10)];
            if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        return w;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0; bus.out_ready = 1'b0;

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        checkResetState("reset");

        applyStimulus(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0, 1'b0);
        checkOutput("addi");
        check("addi.imm_const", 64'(bus.imm), 64'd5);
        check("addi.type_const", 64'(bus.instr_type), 64'(6'b000010));

        applyStimulus(1'b1, 32'h4020_8133, 32'h104, 1'b1, 1'b0, 1'b0);
        checkOutput("sub");
        check("sub.alu_const", 64'(bus.alu_op), 64'd1);
        applyStimulus(1'b1, 32'h0020_A223, 32'h108, 1'b1, 1'b0, 1'b0);
        checkOutput("sw");
        check("sw.memwr_const", 64'({bus.mem_wr, bus.mem_size, bus.rd_we}), 64'({1'b1, 3'b010, 1'b0}));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain1");

        applyStimulus(1'b1, 32'h0020_8463, 32'h10C, 1'b0, 1'b0, 1'b0);
        checkOutput("beq_load");
        applyStimulus(1'b1, 32'h1234_52B7, 32'h110, 1'b0, 1'b0, 1'b0);
        checkOutput("beq_hold1");
        check("skid_full.in_ready", 64'(bus.in_ready), 64'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("beq_hold2");
        check("beq.imm_const", 64'(bus.imm), 64'd8);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("lui_out");
        check("lui.imm_const", 64'(bus.imm), 64'h1234_5000);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain2");

        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h200, 1'b1, 1'b0, 1'b0);
        checkOutput("ill_ones");
        applyStimulus(1'b1, 32'h0000_A063, 32'h204, 1'b1, 1'b0, 1'b0);
        checkOutput("ill_branch");
        check("ill.const", 64'({bus.out_valid, bus.illegal, bus.instr_type}), 64'({1'b1, 1'b1, 6'b0}));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain3");

        applyStimulus(1'b1, 32'h0050_0093, 32'h300, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h4020_8133, 32'h304, 1'b0, 1'b0, 1'b0);
        checkOutput("full");
        applyStimulus(1'b1, 32'h1234_52B7, 32'h308, 1'b0, 1'b1, 1'b0);
        checkOutput("flushed");
        check("flush.const", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_flush");

        applyStimulus(1'b1, 32'h0000_0013, 32'h400, 1'b1, 1'b0, 1'b0);
        checkOutput("nop");
        check("nop.rd_we_const", 64'(bus.rd_we), 64'd0);
        applyStimulus(1'b1, 32'h0050_0093, 32'h500, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0020_A223, 32'h504, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1234_52B7, 32'h508, 1'b0, 1'b1, 1'b1);
        checkResetState("stall_reset");
        checkOutput("stall_reset");

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, randInstr(), $urandom & 32'hFFFF_FFFC,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
            checkOutput("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_dec_stage.md
Name: instr_dec_stage

Overview:
Registered, handshaked RV32I decode stage that replaces the purely combinational decoder.
- Accepts fetched instruction words and fully decodes all RV32I base opcodes into control fields: instruction class, ALU op, branch op, memory op, register indices and sign-extended immediate.
- Adds a 2-entry skid buffer, pipeline flush, and illegal-instruction detection.
- Sits between the fetch stage and the register-read/execute stage.

Parameters:
WIDTH, 32, instruction/PC/immediate width (RV32I encoding fixed; only 32 supported)
INSTR_TYPES, 6, one-hot class vector width, MSB..LSB = J U B S I R
ALU_OP, 4, alu_op field width
BR_OP, 3, branch_op field width
REG_IDX, 5, register index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous kill of all held and incoming instructions
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept
in_instr  in  WIDTH  instruction word
in_pc  in  WIDTH  PC of instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts
out_pc  out  WIDTH  registered PC
instr_type  out  INSTR_TYPES  one-hot class, all-zero if illegal
alu_en  out  1  ALU used
alu_op  out  ALU_OP  ALU function
branch_en  out  1  conditional branch
branch_op  out  BR_OP  branch compare (= funct3)
jump  out  1  JAL/JALR
mem_rd, mem_wr  out  1 each  load/store
mem_size  out  3  funct3 of load/store (bit2 = unsigned)
rd, rs1, rs2  out  REG_IDX each  register indices (instr[11:7], [19:15], [24:20])
rd_we  out  1  writes rd (forced 0 when rd==0)
imm  out  WIDTH  sign-extended immediate per format (I,S,B,U,J); 0 for R
illegal  out  1  unrecognised encoding

Behaviour:
- Reset: out_valid=0, skid empty, in_ready=1. All other outputs are 0, with instr_type=0.
- Transfer: occurs on in_valid&in_ready (input side) and on out_valid&out_ready (output side).
- Latency: 1 cycle from input transfer to out_valid when the output register is empty or draining. Decode is combinational on the input word; the result is registered.
- Output register plus one skid entry; in_ready = skid empty (registered, never derived from out_ready).
- Input transfer while the output is held (out_valid & !out_ready): the decoded bundle goes to skid. in_ready then drops next cycle.
- Output transfer while skid is full: skid moves to the output register. in_ready rises next cycle.
- Simultaneous input and output transfer with skid empty: the new bundle loads the output directly and out_valid stays 1.
- Output fields stay stable while out_valid & !out_ready.
- flush: next cycle out_valid=0 and skid empty. An in_instr presented in the flush cycle is discarded. flush with rst: rst wins, with identical effect.
- alu_op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
  - LUI: PASSB.
  - AUIPC/JAL/JALR/loads/stores: ADD.
  - Branches: SUB.
  - OP-IMM uses funct3; SRAI/SRA is selected by instr[30].
- alu_en=1 for all legal classes except FENCE/ECALL/EBREAK.
- Class mapping:
  - LUI/AUIPC: U.
  - JAL: J.
  - JALR, loads, OP-IMM, FENCE, SYSTEM: I.
  - Stores: S.
  - Branches: B.
  - OP: R.
- rd_we=1 for U, J, JALR, loads, OP-IMM, OP.
- Illegal when any of the following hold:
  - opcode[1:0]!=11 or opcode unlisted;
  - branch funct3 010/011;
  - load funct3 011/110/111;
  - store funct3 >010;
  - OP funct7 not 0000000, or 0100000 with funct3 other than 000/101;
  - OP-IMM shift funct7 invalid (SLLI needs 0000000; SRLI/SRAI need 0000000/0100000);
  - JALR funct3!=0.
- Illegal bundles still handshake with out_valid=1, illegal=1, and all enables (alu_en, branch_en, jump, mem_rd, mem_wr, rd_we) forced 0.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093), pc=0x100, out_ready=1 -> next cycle out_valid=1, type=000010, alu_op=0, rd=1, rs1=0, imm=5, rd_we=1, out_pc=0x100.
- SUB x2,x1,x2 (0x40208133) then SW x2,4(x1) (0x0020A223) back-to-back -> first bundle: type=000001, alu_op=1. Second bundle: type=000100, mem_wr=1, mem_size=010, imm=4, rd_we=0. Both on consecutive cycles.
- BEQ x1,x2,+8 (0x00208463) with out_ready=0 for 3 cycles while LUI x5,0x12345 (0x123452B7) follows -> BEQ held stable (branch_en=1, branch_op=0, imm=8), LUI in skid, in_ready=0. On out_ready=1, BEQ then LUI (imm=0x12345000, alu_op=10) emerge in order with no loss.
- 0xFFFFFFFF and 0x0000A063 (branch funct3=010) -> illegal=1, instr_type=0, all enables 0, out_valid=1.
- Output and skid both full, assert flush one cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no flushed bundle ever appears.
- ADDI rd=x0 (0x00000013, NOP) -> rd_we=0. Assert rst during a stall -> all outputs return to reset values the next cycle.
